// File: rtl/turn_controller_pkg.sv
// Shared definitions for the turn sequencer: state encodings, ring defaults
// and the player-count decode.
package turn_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_CHECK     = 3'd2,
        ST_MOVE      = 3'd3,
        ST_TURN_END  = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    localparam int MAX_PLAYERS   = 4;
    localparam int DEF_NUM_TILES = 16;
    localparam int DEF_POS_W     = 4;

    // Index of the last active player: n_sel 0/1 -> 2 players, 2 -> 3, 3 -> 4.
    function automatic logic [1:0] last_player_idx(input logic [1:0] n_sel);
        return (n_sel < 2'd2) ? 2'd1 : n_sel;
    endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Game/datapath signal bundle between the turn sequencer (slave) and the
// board environment plus tile datapath (master).
interface turn_controller_if #(
    parameter int POS_W = 4
);
    logic               start;
    logic [1:0]         n_sel;
    logic               sel_valid;
    logic [POS_W-1:0]   sel_tile;
    logic               cmp_done;
    logic               cmp_match;
    logic               cmp_req;
    logic [POS_W-1:0]   cmp_tile;
    logic [POS_W-1:0]   target_pos;
    logic [1:0]         cur_player;
    logic               next_turn;
    logic [4*POS_W-1:0] pos_flat;
    logic               winner_valid;
    logic [1:0]         winner;
    logic [2:0]         state_dbg;

    modport master (
        output start, n_sel, sel_valid, sel_tile, cmp_done, cmp_match,
        input  cmp_req, cmp_tile, target_pos, cur_player, next_turn,
               pos_flat, winner_valid, winner, state_dbg
    );

    modport slave (
        input  start, n_sel, sel_valid, sel_tile, cmp_done, cmp_match,
        output cmp_req, cmp_tile, target_pos, cur_player, next_turn,
               pos_flat, winner_valid, winner, state_dbg
    );
endinterface

// File: rtl/turn_controller_timer.sv
// Per-turn idle counter: counts while enabled, flags the last allowed cycle,
// and saturates there so it can never wrap back into a fresh turn.
module turn_timer #(
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && count != LAST)
            count <= count + 1'b1;
    end

    assign expire = (count == LAST);
endmodule

// File: rtl/turn_controller.sv
// Chicken Cha-Cha-Cha game sequencer: turn FSM, per-player ring positions and
// lap counts, compare request issue to the tile datapath, winner detection.
module turn_controller
    import turn_controller_pkg::*;
#(
    parameter int NUM_TILES   = DEF_NUM_TILES,
    parameter int POS_W       = DEF_POS_W,
    parameter int WIN_LAPS    = 2,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    turn_controller_if.slave bus
);
    state_t state, state_nxt;

    logic [POS_W-1:0] pos  [MAX_PLAYERS];
    logic [1:0]       laps [MAX_PLAYERS];
    logic [1:0]       cur;
    logic [1:0]       last_player;
    logic [1:0]       winner;
    logic [POS_W-1:0] cmp_tile;
    logic             cmp_req;
    logic             next_turn;

    logic             do_start, do_sel, do_move, do_tend;
    logic             tmr_expire;
    logic [POS_W-1:0] pos_cur;
    logic [1:0]       laps_inc;
    logic             wrap, win;

    assign pos_cur  = pos[cur];
    assign laps_inc = laps[cur] + 2'd1;
    assign wrap     = (pos_cur == POS_W'(NUM_TILES - 1));
    assign win      = wrap && (laps_inc == 2'(WIN_LAPS));

    turn_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (do_start | do_move | do_tend),
        .en     (state == ST_SELECT),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_sel    = 1'b0;
        do_move   = 1'b0;
        do_tend   = 1'b0;
        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (bus.start) begin
                    do_start  = 1'b1;
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // A flip on the expiry cycle still counts as a flip.
                if (bus.sel_valid) begin
                    do_sel    = 1'b1;
                    state_nxt = ST_CHECK;
                end else if (tmr_expire) begin
                    state_nxt = ST_TURN_END;
                end
            end
            ST_CHECK: begin
                if (bus.cmp_done)
                    state_nxt = bus.cmp_match ? ST_MOVE : ST_TURN_END;
            end
            ST_MOVE: begin
                do_move   = 1'b1;
                state_nxt = win ? ST_GAME_OVER : ST_SELECT;
            end
            ST_TURN_END: begin
                do_tend   = 1'b1;
                state_nxt = ST_SELECT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= '0;
            last_player <= 2'd1;
            winner      <= '0;
            cmp_tile    <= '0;
            cmp_req     <= 1'b0;
            next_turn   <= 1'b0;
            for (int p = 0; p < MAX_PLAYERS; p++) begin
                pos[p]  <= '0;
                laps[p] <= '0;
            end
        end else begin
            cmp_req   <= do_sel;
            next_turn <= do_tend;
            if (do_start) begin
                cur         <= '0;
                winner      <= '0;
                last_player <= last_player_idx(bus.n_sel);
                for (int p = 0; p < MAX_PLAYERS; p++) begin
                    pos[p]  <= '0;
                    laps[p] <= '0;
                end
            end
            if (do_sel)
                cmp_tile <= bus.sel_tile;
            if (do_move) begin
                // Ring length is a power of two, so the increment wraps itself.
                pos[cur] <= pos_cur + 1'b1;
                if (wrap)
                    laps[cur] <= laps_inc;
                if (win)
                    winner <= cur;
            end
            if (do_tend)
                cur <= (cur == last_player) ? 2'd0 : cur + 2'd1;
        end
    end

    assign bus.cmp_req      = cmp_req;
    assign bus.cmp_tile     = cmp_tile;
    assign bus.target_pos   = pos_cur + 1'b1;
    assign bus.cur_player   = cur;
    assign bus.next_turn    = next_turn;
    assign bus.winner_valid = (state == ST_GAME_OVER);
    assign bus.winner       = winner;
    assign bus.state_dbg    = state;

    for (genvar p = 0; p < MAX_PLAYERS; p++) begin : g_pos
        assign bus.pos_flat[p*POS_W +: POS_W] = pos[p];
    end
endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: fixed vector table, hand-written corner sequences
// and random play, every cycle also compared against a rule-level game model.
module tb_turn_controller;
    localparam int NT = 16;
    localparam int TO = 8;
    localparam int WL = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    turn_controller_if #(.POS_W(4)) bus ();

    turn_controller #(.NUM_TILES(NT), .POS_W(4), .WIN_LAPS(WL), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Game model: phase numbers follow the documented state_dbg values.
    int m_phase, m_cur, m_players, m_idle, m_tile, m_winner;
    int m_pos [4];
    int m_laps[4];
    bit m_req, m_nt;

    task automatic model_reset();
        m_phase = 0; m_cur = 0; m_players = 2; m_idle = 0; m_tile = 0; m_winner = 0;
        m_req = 0; m_nt = 0;
        for (int p = 0; p < 4; p++) begin m_pos[p] = 0; m_laps[p] = 0; end
    endtask

    task automatic model_step(input bit r, s, input int ns, input bit sv, input int st,
                              input bit cd, cm);
        if (r) begin model_reset(); return; end
        m_req = 0;
        m_nt  = 0;
        case (m_phase)
            0, 5: if (s) begin
                m_players = (ns < 2) ? 2 : ns + 1;
                for (int p = 0; p < 4; p++) begin m_pos[p] = 0; m_laps[p] = 0; end
                m_cur = 0; m_idle = 0; m_winner = 0; m_phase = 1;
            end
            1: begin
                if (sv) begin m_tile = st; m_req = 1; m_phase = 2; end
                else if (m_idle == TO - 1) m_phase = 4;
                m_idle++;
            end
            2: if (cd) m_phase = cm ? 3 : 4;
            3: begin
                m_pos[m_cur] = (m_pos[m_cur] + 1) % NT;
                if (m_pos[m_cur] == 0) m_laps[m_cur]++;
                if (m_pos[m_cur] == 0 && m_laps[m_cur] == WL) begin
                    m_winner = m_cur; m_phase = 5;
                end else begin
                    m_idle = 0; m_phase = 1;
                end
            end
            4: begin
                m_nt = 1; m_cur = (m_cur + 1) % m_players; m_idle = 0; m_phase = 1;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_cmp(input string nm);
        logic [35:0] act, exp;
        act = {bus.state_dbg, bus.cur_player, bus.target_pos, bus.cmp_req, bus.next_turn,
               bus.cmp_tile, bus.pos_flat, bus.winner_valid, bus.winner};
        exp = {3'(m_phase), 2'(m_cur), 4'((m_pos[m_cur] + 1) % NT), m_req, m_nt, 4'(m_tile),
               4'(m_pos[3]), 4'(m_pos[2]), 4'(m_pos[1]), 4'(m_pos[0]),
               (m_phase == 5), 2'(m_winner)};
        chk(nm, act, exp);
    endtask

    task automatic cyc(input string nm, input bit r, s, input logic [1:0] ns, input bit sv,
                       input logic [3:0] st, input bit cd, cm);
        rst = r; bus.start = s; bus.n_sel = ns; bus.sel_valid = sv; bus.sel_tile = st;
        bus.cmp_done = cd; bus.cmp_match = cm;
        @(posedge clk);
        model_step(r, s, int'(ns), sv, int'(st), cd, cm);
        #1;
        model_cmp(nm);
    endtask

    task automatic idle(input string nm);
        cyc(nm, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic       r, s;
        logic [1:0] ns;
        logic       sv;
        logic [3:0] st;
        logic       cd, cm;
        logic [2:0] e_state;
        logic [1:0] e_cur;
        logic [3:0] e_tgt;
        logic       e_req, e_nt;
        logic [3:0] e_tile;
    } vec_t;

    vec_t tbl[15];

    initial begin
        model_reset();
        //           r     s     ns    sv    tile   cd    cm   | st    cur   tgt   req   nt    tile
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd1, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 3'd1, 2'd0, 4'd1, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b1, 4'd7, 1'b0, 1'b0, 3'd2, 2'd0, 4'd1, 1'b1, 1'b0, 4'd7};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd2, 2'd0, 4'd1, 1'b0, 1'b0, 4'd7};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd3, 2'd0, 4'd1, 1'b0, 1'b0, 4'd7};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd1, 2'd0, 4'd2, 1'b0, 1'b0, 4'd7};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 4'd3, 1'b0, 1'b0, 3'd2, 2'd0, 4'd2, 1'b1, 1'b0, 4'd3};
        tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd4, 2'd0, 4'd2, 1'b0, 1'b0, 4'd3};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd1, 2'd1, 4'd1, 1'b0, 1'b1, 4'd3};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 4'd5, 1'b0, 1'b0, 3'd2, 2'd1, 4'd1, 1'b1, 1'b0, 4'd5};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd4, 2'd1, 4'd1, 1'b0, 1'b0, 4'd5};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd1, 2'd2, 4'd1, 1'b0, 1'b1, 4'd5};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 4'd9, 1'b0, 1'b0, 3'd2, 2'd2, 4'd1, 1'b1, 1'b0, 4'd9};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd4, 2'd2, 4'd1, 1'b0, 1'b0, 4'd9};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd1, 2'd0, 4'd2, 1'b0, 1'b1, 4'd9};

        for (int i = 0; i < 15; i++) begin
            cyc("tbl_model", tbl[i].r, tbl[i].s, tbl[i].ns, tbl[i].sv, tbl[i].st,
                tbl[i].cd, tbl[i].cm);
            chk($sformatf("tbl%0d_state", i), 36'(bus.state_dbg),  36'(tbl[i].e_state));
            chk($sformatf("tbl%0d_cur", i),   36'(bus.cur_player), 36'(tbl[i].e_cur));
            chk($sformatf("tbl%0d_tgt", i),   36'(bus.target_pos), 36'(tbl[i].e_tgt));
            chk($sformatf("tbl%0d_req", i),   36'(bus.cmp_req),    36'(tbl[i].e_req));
            chk($sformatf("tbl%0d_nt", i),    36'(bus.next_turn),  36'(tbl[i].e_nt));
            chk($sformatf("tbl%0d_tile", i),  36'(bus.cmp_tile),   36'(tbl[i].e_tile));
        end
        chk("pos_after_tbl", 36'(bus.pos_flat), 36'h0001);

        // Timeout: the 8th idle SELECT cycle hands the turn over.
        for (int i = 0; i < TO - 1; i++) begin
            idle("to_wait");
            chk("to_wait_state", 36'(bus.state_dbg), 36'd1);
        end
        idle("to_fire");
        chk("to_fire_state", 36'(bus.state_dbg), 36'd4);
        idle("to_handover");
        chk("to_nt", 36'(bus.next_turn), 36'd1);
        chk("to_cur", 36'(bus.cur_player), 36'd1);

        // A flip exactly on the expiry cycle wins over the timeout.
        for (int i = 0; i < TO - 1; i++) idle("to_edge_wait");
        cyc("to_edge_sel", 1'b0, 1'b0, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0);
        chk("to_edge_state", 36'(bus.state_dbg), 36'd2);
        chk("to_edge_req", 36'(bus.cmp_req), 36'd1);
        cyc("to_edge_miss", 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle("to_edge_next");
        chk("to_edge_cur", 36'(bus.cur_player), 36'd2);

        // start mid-game is ignored.
        cyc("start_ign", 1'b0, 1'b1, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("start_ign_state", 36'(bus.state_dbg), 36'd1);
        chk("start_ign_cur", 36'(bus.cur_player), 36'd2);

        // Reset while waiting on the compare; a late cmp_done changes nothing.
        cyc("rst_chk_sel", 1'b0, 1'b0, 2'd0, 1'b1, 4'd4, 1'b0, 1'b0);
        cyc("rst_chk_rst", 1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("rst_chk_state", 36'(bus.state_dbg), 36'd0);
        chk("rst_chk_outs", {bus.cmp_req, bus.next_turn, bus.cmp_tile, bus.pos_flat,
                             bus.winner_valid, bus.cur_player}, 36'd0);
        cyc("rst_late_done", 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("rst_late_state", 36'(bus.state_dbg), 36'd0);
        chk("rst_late_pos", 36'(bus.pos_flat), 36'd0);

        // Sixteen straight matches complete one lap and win for player 0.
        cyc("win_start", 1'b0, 1'b1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < NT; i++) begin
            cyc("win_sel", 1'b0, 1'b0, 2'd0, 1'b1, 4'(i), 1'b0, 1'b0);
            cyc("win_done", 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b1);
            idle("win_move");
            if (i < NT - 1) chk("win_pos0", 36'(bus.pos_flat[3:0]), 36'(i + 1));
        end
        chk("win_state", 36'(bus.state_dbg), 36'd5);
        chk("win_valid", 36'(bus.winner_valid), 36'd1);
        chk("win_who", 36'(bus.winner), 36'd0);
        chk("win_pos", 36'(bus.pos_flat), 36'd0);
        cyc("win_sel_ign", 1'b0, 1'b0, 2'd0, 1'b1, 4'd3, 1'b0, 1'b0);
        chk("win_sel_state", 36'(bus.state_dbg), 36'd5);
        chk("win_sel_req", 36'(bus.cmp_req), 36'd0);
        cyc("win_restart", 1'b0, 1'b1, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("restart_state", 36'(bus.state_dbg), 36'd1);
        chk("restart_valid", 36'(bus.winner_valid), 36'd0);

        // Random play against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc("rand",
                ($urandom_range(0, 199) == 0),
                ($urandom_range(0, 19) == 0),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0),
                4'($urandom_range(0, 15)),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
